// File: rtl/ddr_capture_writer.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// ddr_capture_writer - drains an FWFT ADC FIFO into an MCB write port in fixed
// bursts; ring capture with trigger tracking or one-shot linear fill.
// Revision: 1.0
// =============================================================================
module ddr_capture_writer #(
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 64,
   parameter int ADDR_W    = 30,
   parameter int DEPTH_W   = 16,
   parameter int POST_W    = 24
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   cfg_base_addr,
   input  logic [DEPTH_W-1:0]  cfg_depth_bursts,
   input  logic [POST_W-1:0]   cfg_post_words,
   input  logic                cfg_circular,
   input  logic                capture_arm,
   input  logic                trig_in,
   input  logic [DATA_W-1:0]   fifo_dout,
   input  logic                fifo_empty,
   input  logic                fifo_has_burst,
   output logic                fifo_rd_en,
   output logic                mcb_cmd_en,
   output logic [2:0]          mcb_cmd_instr,
   output logic [5:0]          mcb_cmd_bl,
   output logic [ADDR_W-1:0]   mcb_cmd_byte_addr,
   input  logic                mcb_cmd_full,
   output logic                mcb_wr_en,
   output logic [DATA_W-1:0]   mcb_wr_data,
   output logic [DATA_W/8-1:0] mcb_wr_mask,
   input  logic                mcb_wr_full,
   output logic                busy,
   output logic                done,
   output logic                triggered,
   output logic                wrapped,
   output logic [ADDR_W-1:0]   trig_addr,
   output logic [ADDR_W-1:0]   end_addr
);

   localparam int                BYTES         = DATA_W / 8;
   localparam int                CNT_W         = $clog2(BURST_LEN + 1);
   localparam logic [ADDR_W-1:0] c_burst_bytes = ADDR_W'(BURST_LEN * BYTES);
   localparam logic [ADDR_W-1:0] c_word_bytes  = ADDR_W'(BYTES);
   localparam logic [CNT_W-1:0]  c_last_word   = CNT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0]  c_burst_len   = CNT_W'(BURST_LEN);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FILL_WAIT = 3'd1,
      ST_FILL      = 3'd2,
      ST_CMD       = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [DEPTH_W-1:0]  r_burst_idx;
   logic [CNT_W-1:0]    r_word_cnt;
   logic [POST_W-1:0]   r_post_cnt;
   logic                r_trig_prev;
   logic                r_triggered;
   logic                r_trig_pend;
   logic                r_wrapped;
   logic [ADDR_W-1:0]   r_trig_addr;
   logic [ADDR_W-1:0]   r_end_addr;

   logic [DEPTH_W-1:0]  w_last_idx;
   logic                w_last;
   logic [ADDR_W-1:0]   w_burst_addr;
   logic [ADDR_W-1:0]   w_word_addr;
   logic                w_active;
   logic                w_wr;
   logic                w_cmd_fire;
   logic                w_trig_edge;
   logic                w_stop;

   // A zero depth behaves as a single-burst ring.
   assign w_last_idx   = (cfg_depth_bursts == '0) ? '0 : cfg_depth_bursts - DEPTH_W'(1);
   assign w_last       = (r_burst_idx == w_last_idx);
   assign w_burst_addr = cfg_base_addr + ADDR_W'(r_burst_idx) * c_burst_bytes;
   assign w_word_addr  = w_burst_addr + ADDR_W'(r_word_cnt) * c_word_bytes;
   assign w_active     = (r_state == ST_FILL_WAIT) || (r_state == ST_FILL) || (r_state == ST_CMD);
   assign w_wr         = (r_state == ST_FILL) && !fifo_empty && !mcb_wr_full && (r_word_cnt < c_burst_len);
   assign w_cmd_fire   = (r_state == ST_CMD) && !mcb_cmd_full;
   assign w_trig_edge  = cfg_circular && w_active && trig_in && !r_trig_prev && !r_triggered;
   // Ring stops only once the trigger word itself has landed and enough words followed it.
   assign w_stop       = cfg_circular ? (r_triggered && !r_trig_pend && (r_post_cnt >= cfg_post_words))
                                      : w_last;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:      if (capture_arm) w_state_nxt = ST_FILL_WAIT;
         ST_FILL_WAIT: begin
            if (!capture_arm)                       w_state_nxt = ST_IDLE;
            else if (fifo_has_burst && !mcb_wr_full) w_state_nxt = ST_FILL;
         end
         ST_FILL:      if (w_wr && (r_word_cnt == c_last_word)) w_state_nxt = ST_CMD;
         ST_CMD: begin
            if (w_cmd_fire) begin
               if (w_stop)            w_state_nxt = ST_DONE;
               else if (!capture_arm) w_state_nxt = ST_IDLE;
               else                   w_state_nxt = ST_FILL_WAIT;
            end
         end
         ST_DONE:      if (!capture_arm) w_state_nxt = ST_IDLE;
         default:      w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_burst_idx <= '0;
         r_word_cnt  <= '0;
         r_post_cnt  <= '0;
         r_trig_prev <= 1'b0;
         r_triggered <= 1'b0;
         r_trig_pend <= 1'b0;
         r_wrapped   <= 1'b0;
         r_trig_addr <= '0;
         r_end_addr  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         // Tracked in IDLE too, so a level already high at arm is not an edge.
         r_trig_prev <= trig_in;
         if (r_state == ST_IDLE) begin
            r_burst_idx <= '0;
            r_word_cnt  <= '0;
            r_post_cnt  <= '0;
            r_triggered <= 1'b0;
            r_trig_pend <= 1'b0;
            r_wrapped   <= 1'b0;
         end else begin
            if (w_wr) r_word_cnt <= r_word_cnt + CNT_W'(1);

            if (w_trig_edge) begin
               r_triggered <= 1'b1;
               if (w_wr) r_trig_addr <= w_word_addr;
               else      r_trig_pend <= 1'b1;
            end else if (r_trig_pend && w_wr) begin
               r_trig_addr <= w_word_addr;
               r_trig_pend <= 1'b0;
            end else if (r_triggered && !r_trig_pend && w_wr && (r_post_cnt != '1)) begin
               r_post_cnt <= r_post_cnt + POST_W'(1);
            end

            if (w_cmd_fire) begin
               r_end_addr <= w_burst_addr;
               r_word_cnt <= '0;
               if (w_last) begin
                  r_burst_idx <= '0;
                  if (cfg_circular) r_wrapped <= 1'b1;
               end else begin
                  r_burst_idx <= r_burst_idx + DEPTH_W'(1);
               end
            end
         end
      end
   end

   assign fifo_rd_en        = w_wr;
   assign mcb_wr_en         = w_wr;
   assign mcb_wr_data       = fifo_dout;
   assign mcb_wr_mask       = '0;
   assign mcb_cmd_instr     = 3'b000;
   assign mcb_cmd_bl        = 6'(BURST_LEN - 1);
   assign mcb_cmd_en        = w_cmd_fire;
   assign mcb_cmd_byte_addr = (r_state == ST_CMD) ? w_burst_addr : '0;
   assign busy              = w_active;
   assign done              = (r_state == ST_DONE);
   assign triggered         = r_triggered;
   assign wrapped           = r_wrapped;
   assign trig_addr         = r_trig_addr;
   assign end_addr          = r_end_addr;

endmodule
`default_nettype wire
